// File: rtl/clock_display_scanner.sv
// Multiplexed 6-digit 7-segment scanner for the alarm clock core.
// It latches one coherent snapshot per scan frame, can blank the hour leading
// zero, and blinks the whole display while the snapshotted alarm is active.
module clock_display_scanner #(
  parameter int unsigned SCAN_DIV     = 4,
  parameter int unsigned BLINK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] H_d1,
  input  logic [3:0] H_d0,
  input  logic [3:0] M_d1,
  input  logic [3:0] M_d0,
  input  logic [3:0] S_d1,
  input  logic [3:0] S_d0,
  input  logic       Alarm_in,
  input  logic       blank_lead,
  input  logic       disp_en,
  output logic [6:0] seg,
  output logic [5:0] an,
  output logic       dp
);

  localparam int unsigned PRE_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(BLINK_FRAMES - 1);
  localparam logic [2:0]       IDX_LAST = 3'd5;

  typedef struct packed {
    logic [1:0] h_d1;
    logic [3:0] h_d0;
    logic [3:0] m_d1;
    logic [3:0] m_d0;
    logic [3:0] s_d1;
    logic [3:0] s_d0;
    logic       blank_lead;
    logic       alarm;
  } snap_t;

  logic [PRE_W-1:0] pre;
  logic [2:0]       idx;
  snap_t            snap;
  logic [FC_W-1:0]  frame_cnt;
  logic             blink_phase;

  logic             tick_c;
  logic             frame_start_c;
  logic [3:0]       digit_c;
  logic [6:0]       seg_c;
  logic [5:0]       an_c;
  logic             dp_c;
  logic             off_c;

  assign tick_c        = (pre == PRE_LAST);
  assign frame_start_c = (pre == '0) && (idx == 3'd0);

  // Scan timing, per-frame snapshot and blink phase tracking.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre         <= '0;
      idx         <= '0;
      snap        <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      pre <= tick_c ? '0 : pre + PRE_W'(1);
      if (tick_c) begin
        idx <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
      end
      if (frame_start_c) begin
        snap <= '{h_d1: H_d1, h_d0: H_d0, m_d1: M_d1, m_d0: M_d0,
                  s_d1: S_d1, s_d0: S_d0, blank_lead: blank_lead,
                  alarm: Alarm_in};
      end
      // Blink always restarts in the visible phase once the alarm drops.
      if (!snap.alarm) begin
        frame_cnt   <= '0;
        blink_phase <= 1'b0;
      end else if (tick_c && (idx == IDX_LAST)) begin
        if (frame_cnt == FC_LAST) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + FC_W'(1);
        end
      end
    end
  end

  // Select the snapshot digit for the current scan position.
  always_comb begin
    digit_c = 4'd0;
    case (idx)
      3'd0:    digit_c = snap.s_d0;
      3'd1:    digit_c = snap.s_d1;
      3'd2:    digit_c = snap.m_d0;
      3'd3:    digit_c = snap.m_d1;
      3'd4:    digit_c = snap.h_d0;
      3'd5:    digit_c = {2'b00, snap.h_d1};
      default: digit_c = 4'd0;
    endcase
  end

  // Segment decode, anode select, separators and the off conditions.
  always_comb begin
    seg_c = 7'b1000000;
    case (digit_c)
      4'd0:    seg_c = 7'b0111111;
      4'd1:    seg_c = 7'b0000110;
      4'd2:    seg_c = 7'b1011011;
      4'd3:    seg_c = 7'b1001111;
      4'd4:    seg_c = 7'b1100110;
      4'd5:    seg_c = 7'b1101101;
      4'd6:    seg_c = 7'b1111101;
      4'd7:    seg_c = 7'b0000111;
      4'd8:    seg_c = 7'b1111111;
      4'd9:    seg_c = 7'b1101111;
      default: seg_c = 7'b1000000;
    endcase
    if ((idx == IDX_LAST) && snap.blank_lead && (snap.h_d1 == 2'd0)) begin
      seg_c = 7'b0000000;
    end

    an_c = 6'b111111;
    case (idx)
      3'd0:    an_c = 6'b111110;
      3'd1:    an_c = 6'b111101;
      3'd2:    an_c = 6'b111011;
      3'd3:    an_c = 6'b110111;
      3'd4:    an_c = 6'b101111;
      3'd5:    an_c = 6'b011111;
      default: an_c = 6'b111111;
    endcase

    dp_c  = (idx == 3'd2) || (idx == 3'd4);
    off_c = !disp_en || (snap.alarm && blink_phase);
    if (off_c) begin
      an_c  = 6'b111111;
      seg_c = 7'b0000000;
      dp_c  = 1'b0;
    end
  end

  // Registered display outputs, blank during reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an  <= 6'b111111;
      seg <= 7'b0000000;
      dp  <= 1'b0;
    end else begin
      an  <= an_c;
      seg <= seg_c;
      dp  <= dp_c;
    end
  end

endmodule

// File: tb/tb_clock_display_scanner.sv
// Randomized bench for clock_display_scanner against a cycle-count model.
module tb_clock_display_scanner;

  localparam int SD = 4;
  localparam int BF = 2;
  localparam int FRAME = 6 * SD;

  logic       clk;
  logic       reset;
  logic [1:0] H_d1;
  logic [3:0] H_d0, M_d1, M_d0, S_d1, S_d0;
  logic       Alarm_in, blank_lead, disp_en;
  logic [6:0] seg;
  logic [5:0] an;
  logic       dp;

  clock_display_scanner #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .reset(reset),
    .H_d1(H_d1), .H_d0(H_d0), .M_d1(M_d1), .M_d0(M_d0),
    .S_d1(S_d1), .S_d0(S_d0),
    .Alarm_in(Alarm_in), .blank_lead(blank_lead), .disp_en(disp_en),
    .seg(seg), .an(an), .dp(dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model state: cycles since release, snapshot contents, blink tracking.
  int         t;
  int         sd [6];
  bit         s_blank, s_alarm;
  int         fc;
  bit         bp;
  logic [13:0] exp_out;
  logic [6:0] seg_tbl [16];

  localparam logic [13:0] OFF = {6'b111111, 7'b0000000, 1'b0};

  task automatic check_eq(input string tag, input logic [13:0] got, input logic [13:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s t=%0t got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
               tag, $time, got[13:8], got[7:1], got[0], want[13:8], want[7:1], want[0]);
    end
  endtask

  task automatic model_reset();
    t = 0; fc = 0; bp = 0; s_blank = 0; s_alarm = 0;
    for (int i = 0; i < 6; i++) sd[i] = 0;
    exp_out = OFF;
  endtask

  // One active edge: output from pre-edge state, then advance the model.
  task automatic model_edge();
    int idx, pre;
    logic [6:0] sg;
    idx = (t / SD) % 6;
    pre = t % SD;
    if (!disp_en || (s_alarm && bp)) begin
      exp_out = OFF;
    end else begin
      sg = seg_tbl[sd[idx]];
      if (idx == 5 && s_blank && sd[5] == 0) sg = 7'b0;
      exp_out = {~(6'b000001 << idx), sg, (idx == 2 || idx == 4) ? 1'b1 : 1'b0};
    end
    if (!s_alarm) begin
      fc = 0; bp = 0;
    end else if (pre == SD - 1 && idx == 5) begin
      if (fc == BF - 1) begin fc = 0; bp = !bp; end
      else fc = fc + 1;
    end
    if (t % FRAME == 0) begin
      sd[0] = int'(S_d0); sd[1] = int'(S_d1); sd[2] = int'(M_d0);
      sd[3] = int'(M_d1); sd[4] = int'(H_d0); sd[5] = int'(H_d1);
      s_blank = blank_lead; s_alarm = Alarm_in;
    end
    t = (t + 1) % FRAME;
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    if (reset) model_edge();
    @(negedge clk);
    check_eq(tag, {an, seg, dp}, exp_out);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    #1;
    model_reset();
    check_eq(tag, {an, seg, dp}, OFF);
    @(negedge clk);
    check_eq(tag, {an, seg, dp}, OFF);
    reset = 1'b1;
  endtask

  task automatic set_time(input int hh, input int mm, input int ss);
    H_d1 = 2'(hh / 10); H_d0 = 4'(hh % 10);
    M_d1 = 4'(mm / 10); M_d0 = 4'(mm % 10);
    S_d1 = 4'(ss / 10); S_d0 = 4'(ss % 10);
  endtask

  initial begin
    seg_tbl[0] = 7'b0111111; seg_tbl[1] = 7'b0000110; seg_tbl[2] = 7'b1011011;
    seg_tbl[3] = 7'b1001111; seg_tbl[4] = 7'b1100110; seg_tbl[5] = 7'b1101101;
    seg_tbl[6] = 7'b1111101; seg_tbl[7] = 7'b0000111; seg_tbl[8] = 7'b1111111;
    seg_tbl[9] = 7'b1101111;
    for (int i = 10; i < 16; i++) seg_tbl[i] = 7'b1000000;

    reset = 1'b1;
    set_time(12, 34, 56);
    Alarm_in = 0; blank_lead = 0; disp_en = 1;
    @(negedge clk);
    do_reset("reset");

    // Basic scan of 12:34:56, with a mid-frame change to 23:59:59.
    for (int c = 0; c < 2 * FRAME; c++) begin
      cycle("scan");
      if (c == 14) set_time(23, 59, 59);
    end

    // Leading-zero blank, dash decode and an alarm blink stretch.
    set_time(5, 12, 34); blank_lead = 1;
    for (int c = 0; c < 2 * FRAME; c++) cycle("blank");
    set_time(15, 4'hC, 0);
    M_d0 = 4'hC;
    for (int c = 0; c < 2 * FRAME; c++) cycle("dash");
    Alarm_in = 1;
    for (int c = 0; c < 6 * FRAME; c++) cycle("blink");
    Alarm_in = 0;
    for (int c = 0; c < 2 * FRAME; c++) cycle("unblink");

    // Reset mid-frame at idx 3 / pre 2, then resume.
    while (t != 3 * SD + 2) cycle("align");
    do_reset("midreset");
    for (int c = 0; c < FRAME; c++) cycle("restart");

    // Randomized soak.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        H_d1 = 2'($urandom_range(0, 3));
        H_d0 = 4'($urandom_range(0, 15));
        M_d1 = 4'($urandom_range(0, 15));
        M_d0 = 4'($urandom_range(0, 15));
        S_d1 = 4'($urandom_range(0, 15));
        S_d0 = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 199) == 0) Alarm_in = !Alarm_in;
      if ($urandom_range(0, 29) == 0) blank_lead = !blank_lead;
      if ($urandom_range(0, 49) == 0) disp_en = !disp_en;
      if ($urandom_range(0, 499) == 0) do_reset("rndreset");
      cycle("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
